// File: rtl/mult_div_seq_if.sv
// Operation request and result bundle for the sequential multiply/divide unit.
// The master issues start/op/a/b and observes busy/done/div_zero/hi/lo.
// op_unsigned exists only when MDU_UNSIGNED_EN is defined.
// Handshake: a request is accepted on a rising edge where start=1 while the
// unit is idle. Requests at any other time are dropped. done (and div_zero
// for a zero divisor) pulses for exactly one cycle per accepted request.
interface mult_div_seq_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MDU_UNSIGNED_EN
    logic        op_unsigned;
`endif
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MDU_UNSIGNED_EN
    modport master (output start, op, a, b, op_unsigned,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b, op_unsigned,
                    output busy, done, div_zero, hi, lo);
`else
    modport master (output start, op, a, b,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/mult_div_seq.sv
// Sequential 32x32 multiply (radix-2 Booth) and restoring divide unit with
// MIPS-style HI/LO result registers. 32 iterations, one bit per clock.
// Optional macro MDU_UNSIGNED_EN adds op_unsigned (MULTU/DIVU behaviour).
// state_dbg exposes the FSM state for observation.
module mult_div_seq (
    input  logic           clock,
    input  logic           reset,
    mult_div_seq_if.slave  mdu,
    output logic [2:0]     state_dbg
);
    typedef enum logic [2:0] {IDLE = 3'd0, MULT = 3'd1, DIV = 3'd2,
                              FIX = 3'd3, DONE = 3'd4} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [32:0] acc;       // Booth partial product / division remainder
    logic [31:0] q;         // multiplier bits / dividend-then-quotient bits
    logic        q_m1;      // Booth look-behind bit
    logic [32:0] m;         // multiplicand (extended) or divisor magnitude
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        zero_div;
    logic        uns;

    logic        uns_in;
    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] mul_acc_n;
    logic [31:0] mul_q_n;
    logic [33:0] div_diff;
    logic [32:0] div_shift;

    assign state_dbg = state;

    // Operand signs and magnitudes seen at the start request
    always_comb begin
`ifdef MDU_UNSIGNED_EN
        uns_in = mdu.op_unsigned;
`else
        uns_in = 1'b0;
`endif
        sa    = ~uns_in & mdu.a[31];
        sb    = ~uns_in & mdu.b[31];
        mag_a = sa ? -mdu.a : mdu.a;
        mag_b = sb ? -mdu.b : mdu.b;
    end

    // One multiply step: Booth add/subtract (or plain add when unsigned), then shift right
    always_comb begin
        mul_sum = acc;
        if (uns) begin
            if (q[0]) mul_sum = acc + m;
        end else begin
            case ({q[0], q_m1})
                2'b01:   mul_sum = acc + m;
                2'b10:   mul_sum = acc - m;
                default: mul_sum = acc;
            endcase
        end
        // Unsigned carry-out shifts down as data; signed keeps the sign bit
        mul_acc_n = {(uns ? 1'b0 : mul_sum[32]), mul_sum[32:1]};
        mul_q_n   = {mul_sum[0], q[31:1]};
    end

    // One restoring-division step on magnitudes: trial subtract of shifted remainder
    always_comb begin
        div_shift = {acc[31:0], q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, m[31:0]};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            acc          <= 33'd0;
            q            <= 32'd0;
            q_m1         <= 1'b0;
            m            <= 33'd0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_div     <= 1'b0;
            uns          <= 1'b0;
            mdu.busy     <= 1'b0;
            mdu.done     <= 1'b0;
            mdu.div_zero <= 1'b0;
            mdu.hi       <= 32'd0;
            mdu.lo       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu.start) begin
                        cnt      <= 6'd0;
                        acc      <= 33'd0;
                        q_m1     <= 1'b0;
                        uns      <= uns_in;
                        is_div   <= mdu.op;
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        zero_div <= 1'b0;
                        mdu.busy <= 1'b1;
                        if (!mdu.op) begin
                            q     <= mdu.a;
                            m     <= {(uns_in ? 1'b0 : mdu.b[31]), mdu.b};
                            state <= MULT;
                        end else if (mdu.b == 32'd0) begin
                            // Nothing to iterate; report straight from FIX
                            zero_div <= 1'b1;
                            state    <= FIX;
                        end else begin
                            q     <= mag_a;
                            m     <= {1'b0, mag_b};
                            state <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc  <= mul_acc_n;
                    q    <= mul_q_n;
                    q_m1 <= q[0];
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                DIV: begin
                    if (!div_diff[33]) begin
                        acc <= {1'b0, div_diff[31:0]};
                        q   <= {q[30:0], 1'b1};
                    end else begin
                        acc <= {1'b0, div_shift[31:0]};
                        q   <= {q[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    mdu.done <= 1'b1;
                    mdu.busy <= 1'b0;
                    state    <= DONE;
                    if (zero_div) begin
                        mdu.div_zero <= 1'b1;
                    end else if (is_div) begin
                        mdu.lo <= neg_q ? -q : q;
                        mdu.hi <= neg_r ? -acc[31:0] : acc[31:0];
                    end else begin
                        mdu.hi <= acc[31:0];
                        mdu.lo <= q;
                    end
                end
                DONE: begin
                    mdu.done     <= 1'b0;
                    mdu.div_zero <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: vector table, random operands against
// a 64-bit arithmetic model, and hand sequences for divide-by-zero, ignored
// start, and reset abort. Results are checked from a scoreboard queue.
module tb_mult_div_seq;
    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] state_dbg;
    int         checks   = 0;
    int         failures = 0;
    logic [64:0] exp_q[$];
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[12];

    mult_div_seq_if mdu();

    mult_div_seq dut (
        .clock     (clock),
        .reset     (reset),
        .mdu       (mdu),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr, pp;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            pp = sa * sb;
            r  = pp;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            r  = {rr[31:0], qq[31:0]};
        end
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result
    always @(negedge clock) begin
        logic [64:0] e;
        if (!reset && mdu.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("div_zero", {63'd0, mdu.div_zero}, {63'd0, e[64]});
                check("hi", {32'd0, mdu.hi}, {32'd0, e[63:32]});
                check("lo", {32'd0, mdu.lo}, {32'd0, e[31:0]});
            end
        end
    end

    // Driver: issue one operation and follow it to completion
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic [31:0] eh, input logic [31:0] el,
                          input logic dz, input bit interfere);
        int n;
        exp_q.push_back({dz, eh, el});
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
`ifdef MDU_UNSIGNED_EN
        mdu.op_unsigned = uns;
`else
        if (uns) $display("note: unsigned request issued in signed build");
`endif
        @(posedge clock); #1;
        mdu.start = 1'b0;
        check("busy_after_start", {63'd0, mdu.busy}, 64'd1);
        n = 0;
        while (mdu.done !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
            if (interfere && n == 10) begin
                mdu.start = 1'b1;
                mdu.op    = 1'b0;
                mdu.a     = 32'd123;
                mdu.b     = 32'd456;
            end
            if (n == 11) mdu.start = 1'b0;
            if (!dz && n == 16) begin
                check("hi_hold", {32'd0, mdu.hi}, {32'd0, prev_hi});
                check("lo_hold", {32'd0, mdu.lo}, {32'd0, prev_lo});
            end
        end
        check("latency", 64'(n), dz ? 64'd1 : 64'd33);
        check("busy_at_done", {63'd0, mdu.busy}, 64'd0);
        if (interfere) mdu.start = 1'b1;
        @(posedge clock); #1;
        mdu.start = 1'b0;
        check("done_cleared", {63'd0, mdu.done}, 64'd0);
        if (interfere) begin
            @(posedge clock); #1;
            check("start_in_done_ignored", {63'd0, mdu.busy}, 64'd0);
        end
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        logic        rop;
        logic [31:0] ra, rb;
        logic [63:0] r;

        vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[4]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[9]  = '{1'b1, 32'd3,        32'd10,       32'h00000003, 32'h00000000};
        vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
        vecs[11] = '{1'b1, 32'h80000000, 32'd1,        32'h00000000, 32'h80000000};

        // Reset, with start held to show reset wins
        reset     = 1'b1;
        mdu.start = 1'b1;
        mdu.op    = 1'b0;
        mdu.a     = 32'd5;
        mdu.b     = 32'd6;
`ifdef MDU_UNSIGNED_EN
        mdu.op_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, mdu.busy}, 64'd0);
        check("reset_done", {63'd0, mdu.done}, 64'd0);
        check("reset_div_zero", {63'd0, mdu.div_zero}, 64'd0);
        check("reset_hi", {32'd0, mdu.hi}, 64'd0);
        check("reset_lo", {32'd0, mdu.lo}, 64'd0);
        check("reset_state", {61'd0, state_dbg}, 64'd0);
        mdu.start = 1'b0;
        reset     = 1'b0;
        @(posedge clock); #1;

        // Vector table
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);

        // Divide by zero: hi/lo keep the last result
        run_op(1'b1, 32'd5, 32'd0, 1'b0, prev_hi, prev_lo, 1'b1, 1'b0);

        // Second start mid-MULT and start during DONE are ignored
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);

        // Random operands against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 50);
            if (rb == 32'd0) rb = 32'd3;
            r = model(rop, ra, rb);
            run_op(rop, ra, rb, 1'b0, r[63:32], r[31:0], 1'b0, 1'b0);
        end

        // Reset in the middle of a DIV aborts it without a done pulse
        mdu.start = 1'b1;
        mdu.op    = 1'b1;
        mdu.a     = 32'd1000;
        mdu.b     = 32'd3;
        @(posedge clock); #1;
        mdu.start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, mdu.busy}, 64'd0);
        check("abort_done", {63'd0, mdu.done}, 64'd0);
        check("abort_hi", {32'd0, mdu.hi}, 64'd0);
        check("abort_lo", {32'd0, mdu.lo}, 64'd0);
        check("abort_state", {61'd0, state_dbg}, 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        repeat (40) @(posedge clock);
        #1;
        run_op(1'b1, 32'd1000, 32'd3, 1'b0, 32'd1, 32'd333, 1'b0, 1'b0);

`ifdef MDU_UNSIGNED_EN
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op(1'b1, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0);
        mdu.op_unsigned = 1'b0;
`endif

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
